rv32i_instr_encoder: RTL and testbench

//  Streaming RV32I instruction encoder: packs decoded fields (class, ALU op, width, regs, imm) into 32-bit words.

---
 rtl/rv32i_enc_pkg.sv | 77 +++++++
 rtl/rv32i_field_packer.sv | 70 +++++++
 rtl/rv32i_instr_encoder.sv | 144 ++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_enc_pkg.sv
// Shared encoder types: descriptor alphabet, opcodes and funct helpers.
// Optional SLLI/SRLI support in the packer is enabled by RV_ENC_SHIFT_IMM_EN.
package rv32i_enc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CLASS_W = 2;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned MEMW_W  = 2;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 12;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;
  localparam int unsigned OPC_W   = 7;

  typedef enum logic [CLASS_W-1:0] {
    CLS_R     = 2'd0,
    CLS_OPIMM = 2'd1,
    CLS_STORE = 2'd2,
    CLS_LOAD  = 2'd3
  } enc_class_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd7
  } alu_op_t;

  typedef enum logic [MEMW_W-1:0] {
    WID_B = 2'd0,
    WID_H = 2'd1,
    WID_W = 2'd2
  } width_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } enc_state_t;

  typedef struct packed {
    enc_class_t       cls;
    alu_op_t          op;
    width_t           width;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } enc_desc_t;

  localparam logic [OPC_W-1:0]   OPC_OP    = 7'b0110011;
  localparam logic [OPC_W-1:0]   OPC_OPIMM = 7'b0010011;
  localparam logic [OPC_W-1:0]   OPC_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0]   OPC_LOAD  = 7'b0000011;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [F3_W-1:0] f3_of(input alu_op_t op);
    logic [F3_W-1:0] f3;
    case (op)
      ALU_SLL: f3 = 3'b001;
      ALU_XOR: f3 = 3'b100;
      ALU_SRL: f3 = 3'b101;
      ALU_OR:  f3 = 3'b110;
      ALU_AND: f3 = 3'b111;
      default: f3 = 3'b000;
    endcase
    return f3;
  endfunction

  function automatic logic [F7_W-1:0] f7_of(input alu_op_t op);
    return (op == ALU_SUB) ? 7'b0100000 : 7'b0000000;
  endfunction

endpackage

// File: rtl/rv32i_field_packer.sv
// Combinational descriptor-to-instruction packer; illegal descriptors map to NOP.
// RV_ENC_SHIFT_IMM_EN adds SLLI/SRLI under the OPIMM class.
module rv32i_field_packer
  import rv32i_enc_pkg::*;
(
  input  enc_desc_t            i_desc,
  output logic [INSTR_W-1:0]   o_word_c,
  output logic                 o_illegal_c
);

  logic w_op_known;
  logic w_wid_ok;
  logic [F3_W-1:0] w_mem_f3;

  always_comb begin
    w_op_known = 1'b0;
    w_wid_ok   = 1'b0;
    w_mem_f3   = {1'b0, i_desc.width};
    case (i_desc.op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL: w_op_known = 1'b1;
      default: w_op_known = 1'b0;
    endcase
    case (i_desc.width)
      WID_B, WID_H, WID_W: w_wid_ok = 1'b1;
      default: w_wid_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_word_c    = NOP_INSTR;
    o_illegal_c = 1'b0;
    case (i_desc.cls)
      CLS_R: begin
        if (w_op_known)
          o_word_c = {f7_of(i_desc.op), i_desc.rs2, i_desc.rs1, f3_of(i_desc.op), i_desc.rd, OPC_OP};
        else
          o_illegal_c = 1'b1;
      end
      CLS_OPIMM: begin
        case (i_desc.op)
          ALU_ADD, ALU_AND, ALU_OR, ALU_XOR:
            o_word_c = {i_desc.imm, i_desc.rs1, f3_of(i_desc.op), i_desc.rd, OPC_OPIMM};
`ifdef RV_ENC_SHIFT_IMM_EN
          // Shift amount lives in imm[4:0]; upper bits must be clear (no SRAI form)
          ALU_SLL, ALU_SRL: begin
            if (i_desc.imm[11:5] == 7'd0)
              o_word_c = {7'd0, i_desc.imm[4:0], i_desc.rs1, f3_of(i_desc.op), i_desc.rd, OPC_OPIMM};
            else
              o_illegal_c = 1'b1;
          end
`endif
          default: o_illegal_c = 1'b1;
        endcase
      end
      CLS_STORE: begin
        if (w_wid_ok)
          o_word_c = {i_desc.imm[11:5], i_desc.rs2, i_desc.rs1, w_mem_f3, i_desc.imm[4:0], OPC_STORE};
        else
          o_illegal_c = 1'b1;
      end
      default: begin
        if (w_wid_ok)
          o_word_c = {i_desc.imm, i_desc.rs1, w_mem_f3, i_desc.rd, OPC_LOAD};
        else
          o_illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: accepts descriptors, writes packed words to imem sequentially.
// Build with RV_ENC_SHIFT_IMM_EN to allow SLLI/SRLI through the OPIMM class.
module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   prog_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CLASS_W-1:0]  in_class,
  input  logic [ALUOP_W-1:0]  in_alu_op,
  input  logic [MEMW_W-1:0]   in_width,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [IMM_W-1:0]    in_imm,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  input  logic                imem_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  enc_state_t          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_count, w_count_nxt;
  logic [ADDR_W-1:0]   r_len, w_len_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [INSTR_W-1:0]  r_wdata, w_wdata_nxt;
  logic                r_we, w_we_nxt;
  logic                r_busy;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;

  enc_desc_t           w_desc;
  logic [INSTR_W-1:0]  w_word;
  logic                w_illegal;
  logic                w_accept;
  logic                w_wr_done;
  logic                w_in_ready;

  assign w_desc = '{cls:   enc_class_t'(in_class),
                    op:    alu_op_t'(in_alu_op),
                    width: width_t'(in_width),
                    rd:    in_rd,
                    rs1:   in_rs1,
                    rs2:   in_rs2,
                    imm:   in_imm};

  rv32i_field_packer u_packer (
    .i_desc      (w_desc),
    .o_word_c    (w_word),
    .o_illegal_c (w_illegal)
  );

  // Output register can take a new word when empty or draining this cycle
  assign w_in_ready = (r_state == S_RUN) && (r_count < r_len) && (!r_we || imem_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_wr_done  = r_we && imem_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = r_we;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;

    if (w_wr_done) begin
      w_we_nxt   = 1'b0;
      w_addr_nxt = r_addr + ADDR_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_count_nxt = '0;
          w_len_nxt   = prog_len;
          w_addr_nxt  = ADDR_W'(BASE_ADDR);
          w_err_nxt   = 1'b0;
          if (prog_len == '0) w_done_nxt = 1'b1;
          else                w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_wdata_nxt = w_word;
          w_we_nxt    = 1'b1;
          w_count_nxt = r_count + ADDR_W'(1);
          w_err_nxt   = r_err | w_illegal;
          if ((r_count + ADDR_W'(1)) == r_len) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!r_we || imem_ready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_len   <= w_len_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_we    <= w_we_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: default instance plus a 2-bit-address instance at base 3.
module tb_rv32i_instr_encoder;
  import rv32i_enc_pkg::*;

  localparam int unsigned AW0   = 10;
  localparam int unsigned AW1   = 2;
  localparam int unsigned BASE1 = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic [AW0-1:0] len0;
  logic [AW1-1:0] len1;
  logic in_valid;
  logic rdy0, rdy1;
  logic [1:0] in_class;
  logic [3:0] in_alu_op;
  logic [1:0] in_width;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic imem_ready;
  logic we0, we1;
  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;
  logic [31:0] wd0, wd1;
  logic busy0, busy1, done0, done1, err0, err1;

  exp_t q0[$];
  exp_t q1[$];
  int unsigned ea0, ea1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.ADDR_W(AW0), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .prog_len(len0),
    .in_valid(in_valid), .in_ready(rdy0), .in_class(in_class), .in_alu_op(in_alu_op),
    .in_width(in_width), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0), .imem_ready(imem_ready),
    .busy(busy0), .done(done0), .err(err0)
  );

  rv32i_instr_encoder #(.ADDR_W(AW1), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .prog_len(len1),
    .in_valid(in_valid), .in_ready(rdy1), .in_class(in_class), .in_alu_op(in_alu_op),
    .in_width(in_width), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .imem_ready(imem_ready),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cls, input logic [3:0] op, input logic [1:0] wd,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm);
    in_class = cls; in_alu_op = op; in_width = wd;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Holds in_valid until the selected DUT accepts; queues the expected write
  task automatic wait_accept(input int sel, input logic [31:0] exp, input bit push);
    logic r = 1'b0;
    int n = 0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = (sel == 0) ? rdy0 : rdy1;
      n++;
    end
    if (!r) chk($sformatf("in_ready%0d_wait", sel), 32'(r), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      if (sel == 0) begin
        q0.push_back('{addr: 32'(ea0), data: exp});
        ea0 = (ea0 + 1) % (1 << AW0);
      end else begin
        q1.push_back('{addr: 32'(ea1), data: exp});
        ea1 = (ea1 + 1) % (1 << AW1);
      end
    end
  endtask

  task automatic send(input int sel, input logic [1:0] cls, input logic [3:0] op, input logic [1:0] wd,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm, input logic [31:0] exp, input bit push);
    drive(cls, op, wd, rd, rs1, rs2, imm);
    wait_accept(sel, exp, push);
  endtask

  task automatic start_prog(input int sel, input int unsigned len);
    if (sel == 0) begin start0 = 1'b1; len0 = AW0'(len); ea0 = 0; end
    else          begin start1 = 1'b1; len1 = AW1'(len); ea1 = BASE1; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    logic seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? done0 : done1;
    end
    chk($sformatf("done%0d_seen", sel), 32'(seen), 32'd1);
    @(negedge clk);
    chk($sformatf("done%0d_one_cycle", sel), 32'((sel == 0) ? done0 : done1), 32'd0);
    chk($sformatf("busy%0d_after_done", sel), 32'((sel == 0) ? busy0 : busy1), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every completed imem write must match the head of its scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (imem_ready && we0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL wr0_unexpected: got addr %h data %h expected no write", addr0, wd0);
        end else begin
          e = q0.pop_front();
          chk("wr0_addr", 32'(addr0), e.addr);
          chk("wr0_data", wd0, e.data);
        end
      end
      if (imem_ready && we1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL wr1_unexpected: got addr %h data %h expected no write", addr1, wd1);
        end else begin
          e = q1.pop_front();
          chk("wr1_addr", 32'(addr1), e.addr);
          chk("wr1_data", wd1, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; len0 = '0; len1 = '0;
    imem_ready = 1'b1;
    drive(CLS_R, ALU_ADD, WID_B, 5'd0, 5'd0, 5'd0, 12'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_wdata", wd0, 32'd0);
    chk("rst_in_ready", 32'(rdy0), 32'd0);
    chk("rst_addr1", 32'(addr1), 32'd3);
    @(posedge clk); #1;

    // prog_len=0 completes immediately
    start_prog(0, 0);
    wait_done(0);

    // T1
    start_prog(0, 1);
    @(negedge clk);
    chk("t1_busy", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    send(0, CLS_R, ALU_ADD, WID_B, 5'd1, 5'd2, 5'd3, 12'd0, 32'h003100B3, 1'b1);
    wait_done(0);
    chk("t1_err", 32'(err0), 32'd0);

    // T2
    start_prog(0, 2);
    send(0, CLS_R, ALU_SUB, WID_B, 5'd5, 5'd6, 5'd7, 12'd0, 32'h407302B3, 1'b1);
    send(0, CLS_OPIMM, ALU_XOR, WID_B, 5'd1, 5'd1, 5'd0, 12'hFFF, 32'hFFF0C093, 1'b1);
    wait_done(0);

    // T3
    start_prog(0, 4);
    send(0, CLS_STORE, 4'd0, WID_W, 5'd0, 5'd2, 5'd8, 12'd12, 32'h00812623, 1'b1);
    send(0, CLS_LOAD, 4'd0, WID_W, 5'd8, 5'd2, 5'd0, 12'd12, 32'h00C12403, 1'b1);
    send(0, CLS_R, ALU_SLL, WID_B, 5'd3, 5'd4, 5'd5, 12'd0, 32'h005211B3, 1'b1);
    send(0, CLS_OPIMM, ALU_ADD, WID_B, 5'd2, 5'd0, 5'd0, 12'h7FF, 32'h7FF00113, 1'b1);
    wait_done(0);
    chk("t3_err", 32'(err0), 32'd0);

    // T4: stall imem for 3 cycles with a descriptor waiting
    start_prog(0, 3);
    send(0, CLS_R, ALU_OR, WID_B, 5'd1, 5'd2, 5'd3, 12'd0, 32'h003160B3, 1'b1);
    drive(CLS_R, ALU_AND, WID_B, 5'd1, 5'd2, 5'd3, 12'd0);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_we_hold", 32'(we0), 32'd1);
      chk("t4_addr_hold", 32'(addr0), 32'd0);
      chk("t4_wdata_hold", wd0, 32'h003160B3);
      chk("t4_in_ready_low", 32'(rdy0), 32'd0);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    wait_accept(0, 32'h003170B3, 1'b1);
    send(0, CLS_R, ALU_SRL, WID_B, 5'd1, 5'd2, 5'd3, 12'd0, 32'h003150B3, 1'b1);
    wait_done(0);

    // T5: wrap 3,0,1 and start during RUN ignored
    start_prog(1, 3);
    send(1, CLS_R, ALU_ADD, WID_B, 5'd1, 5'd2, 5'd3, 12'd0, 32'h003100B3, 1'b1);
    start1 = 1'b1; len1 = 2'd1;
    @(posedge clk); #1;
    start1 = 1'b0;
    send(1, CLS_R, ALU_SUB, WID_B, 5'd5, 5'd6, 5'd7, 12'd0, 32'h407302B3, 1'b1);
    send(1, CLS_OPIMM, ALU_XOR, WID_B, 5'd1, 5'd1, 5'd0, 12'hFFF, 32'hFFF0C093, 1'b1);
    wait_done(1);

    // T6: illegal descriptors, sticky err, shift-immediate option
    start_prog(0, 2);
    send(0, CLS_OPIMM, ALU_SUB, WID_B, 5'd1, 5'd1, 5'd0, 12'd3, 32'h00000013, 1'b1);
    @(negedge clk);
    chk("t6_err_set", 32'(err0), 32'd1);
    @(posedge clk); #1;
`ifdef RV_ENC_SHIFT_IMM_EN
    send(0, CLS_OPIMM, ALU_SRL, WID_B, 5'd1, 5'd1, 5'd0, 12'd3, 32'h0030D093, 1'b1);
`else
    send(0, CLS_OPIMM, ALU_SRL, WID_B, 5'd1, 5'd1, 5'd0, 12'd3, 32'h00000013, 1'b1);
`endif
    wait_done(0);
    chk("t6_err_sticky", 32'(err0), 32'd1);

    // err cleared by start; then reset aborts with a write in flight
    start_prog(0, 2);
    @(negedge clk);
    chk("t6_err_clear", 32'(err0), 32'd0);
    @(posedge clk); #1;
    send(0, CLS_R, ALU_ADD, WID_B, 5'd1, 5'd2, 5'd3, 12'd0, 32'h003100B3, 1'b0);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy0), 32'd0);
    chk("t6_rst_we", 32'(we0), 32'd0);
    chk("t6_rst_addr", 32'(addr0), 32'd0);
    chk("t6_rst_wdata", wd0, 32'd0);
    chk("t6_rst_done", 32'(done0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;

    start_prog(0, 1);
    send(0, CLS_OPIMM, ALU_OR, WID_B, 5'd1, 5'd2, 5'd0, 12'd5, 32'h00516093, 1'b1);
    wait_done(0);

    repeat (2) @(posedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
